fnd_scan_controller: RTL and testbench
======================================

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles per digit slot (1 kHz slot rate at 100 MHz).
REQ-002 SHALL have parameter DEAD_CYCLES, default 1000, meaning blanked cycles at the start of each slot; legal range 1..SCAN_DIV-2.
REQ-003 SHALL have parameter BLINK_TICKS, default 500, meaning slots per blink half-period.
REQ-004 SHALL have port i_clk, input, 1, the single clock.
REQ-005 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port i_enable, input, 1, scan enable.
REQ-007 SHALL have port i_digit_value, input, 16, four BCD nibbles; digit0 = [3:0], rightmost.
REQ-008 SHALL have port i_blink_mask, input, 4, per-digit blink enable.
REQ-009 SHALL have port i_dp_mask, input, 4, per-digit decimal point on.
REQ-010 SHALL have port i_lzb, input, 1, leading-zero blank for digit3.
REQ-011 SHALL have port o_fnd_com, output, 4, active-low digit commons.
REQ-012 SHALL have port o_fndfont, output, 8, active-low segments; bit7 = dp.
REQ-013 SHALL have port o_frame_start, output, 1, one-cycle pulse at each snapshot.

Function
REQ-014 The prescaler SHALL count 0..SCAN_DIV-1 while i_enable=1; slot tick = count at SCAN_DIV-1.
REQ-015 On slot tick, the digit index SHALL increment modulo 4 (3 -> 0 wrap), and the FSM SHALL enter BLANK with the dead counter cleared.
REQ-016 The FSM SHALL have two states: BLANK and DRIVE. BLANK -> DRIVE after DEAD_CYCLES cycles. DRIVE -> BLANK on slot tick or when i_enable=0.
REQ-017 In BLANK, o_fnd_com SHALL be 4'hF and o_fndfont SHALL be 8'hFF.
REQ-018 In DRIVE, o_fnd_com SHALL be low only at bit[index].
REQ-019 In DRIVE, o_fndfont SHALL be the decoder font of the snapshot nibble[index], with bit7 cleared when dp_mask[index]=1.
REQ-020 Nibble rendering: values 0-9 SHALL render as digits, 4'hA as dp-only (8'h7F), and 4'hB-4'hF as blank (8'hFF, except a dp set by REQ-019).
REQ-021 When the index becomes 0, and on the first cycle after enable rises, i_digit_value, i_blink_mask, i_dp_mask and i_lzb SHALL be captured into snapshot registers, and o_frame_start SHALL pulse for 1 cycle; there SHALL be no mid-frame tearing.
REQ-022 The blink phase SHALL toggle every BLINK_TICKS slot ticks.
REQ-023 When blink phase=1 and snapshot blink_mask[index]=1, o_fndfont SHALL be 8'hFF, including the dp; o_fnd_com is unchanged.
REQ-024 When snapshot lzb=1 and snapshot nibble3=0, the digit3 font SHALL be 8'hFF, ignoring the dp.
REQ-025 o_fnd_com and o_fndfont SHALL be registered, with 1-cycle latency from a state or index change; commons and segments SHALL change on the same edge.
REQ-026 When i_enable=0, the block SHALL force BLANK outputs, clear the prescaler, set the index to 0 and hold the blink phase. On re-enable it SHALL resume at index 0 in BLANK with a fresh snapshot.
REQ-027 If a slot tick and dead-count expiry coincide, the slot tick SHALL win (BLANK, index+1).

Reset
REQ-028 When i_reset=1, the block SHALL asynchronously set o_fnd_com=4'hF, o_fndfont=8'hFF, o_frame_start=0, state=BLANK, index=0, all counters=0, blink phase=0 and snapshots=0.
REQ-029 Reset asserted mid-slot SHALL blank the outputs immediately, with no partial-frame resume. After deassertion, operation SHALL start per REQ-026 when i_enable=1.

Structure
REQ-030 Package fnd_pkg SHALL hold NUM_DIGITS=4, FND_BLANK=8'hFF, COM_OFF=4'hF, FND_DP_ONLY=8'h7F and the state enumeration {BLANK, DRIVE}.
REQ-031 The design SHALL instantiate exactly one sub-module: the existing BCDtoFND_Decoder, shared across all digits and fed by the index-muxed snapshot nibble.
REQ-032 Target size SHALL be 120-250 lines of RTL.

Verification (bench params SCAN_DIV=8, DEAD_CYCLES=2, BLINK_TICKS=4)
REQ-033 Reset scan: release reset with enable=1 and digit_value=16'h1234 -> o_frame_start pulses once. Each 8-cycle slot shows 2 blank cycles, then com=4'b1110 with font 8'h99 ("4"), then com=4'b1101 with 8'hB0, 4'b1011 with 8'hA4, 4'b0111 with 8'hF9, then wraps to 4'b1110.
REQ-034 Snapshot: change digit_value to 16'h5678 while index=1 -> digits 2-3 still show "2","1"; "8" appears only after the next o_frame_start.
REQ-035 Blink and dp: blink_mask=4'b0001 and dp_mask=4'b0010 -> digit0 font alternates between 8'h99 and 8'hFF every 4 slots; digit1 shows 8'h30 (0xB0 with bit7 cleared).
REQ-036 LZB and codes: digit_value=16'h0A0F with i_lzb=1 -> digit3 shows 8'hFF, digit2 8'h7F, digit1 8'hC0, digit0 8'hFF.
REQ-037 Enable/reset mid-slot: drop enable during DRIVE -> next cycle com=4'hF and font=8'hFF. Pulse i_reset asynchronously mid-slot -> outputs blank within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/fnd_scan_controller_pkg.sv
// Shared constants and types for the FND (7-segment) scan controller.
// Holds the digit count, the active-low display constants and the
// two-state scan FSM encoding used by the controller and its decoder.
package fnd_pkg;

  localparam int unsigned NUM_DIGITS  = 4;
  localparam logic [7:0]  FND_BLANK   = 8'hFF;  // all segments and dp off
  localparam logic [3:0]  COM_OFF     = 4'hF;   // all digit commons off
  localparam logic [7:0]  FND_DP_ONLY = 8'h7F;  // only the decimal point lit

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/fnd_scan_controller_if.sv
// Signal bundle between a display-data producer and the scan controller.
//   master : drives enable, digit values and per-digit masks; observes the
//            display pins and the frame_start pulse.
//   slave  : the scan controller side.
// There is no valid/ready handshake: the producer may change the data at any
// time, and the controller accepts it only in the cycle before frame_start
// pulses, so a whole 4-digit frame always shows one coherent snapshot.
interface fnd_scan_controller_if;
  import fnd_pkg::*;

  logic                      enable;
  logic [4*NUM_DIGITS-1:0]   digit_value;
  logic [NUM_DIGITS-1:0]     blink_mask;
  logic [NUM_DIGITS-1:0]     dp_mask;
  logic                      lzb;
  logic [NUM_DIGITS-1:0]     fnd_com;
  logic [7:0]                fndfont;
  logic                      frame_start;

  modport master (
    output enable, digit_value, blink_mask, dp_mask, lzb,
    input  fnd_com, fndfont, frame_start
  );

  modport slave (
    input  enable, digit_value, blink_mask, dp_mask, lzb,
    output fnd_com, fndfont, frame_start
  );

endinterface

// File: rtl/fnd_scan_controller_decoder.sv
// BCDtoFND_Decoder: combinational BCD nibble to active-low segment font.
//   i_bcd  : 4-bit code
//   o_font : {dp, g, f, e, d, c, b, a}, active low
// 0-9 render as digits, 4'hA renders as a lone decimal point, 4'hB-4'hF blank.
module BCDtoFND_Decoder
  import fnd_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [7:0] o_font
);

  always_comb begin
    o_font = FND_BLANK;
    case (i_bcd)
      4'h0: o_font = 8'hC0;
      4'h1: o_font = 8'hF9;
      4'h2: o_font = 8'hA4;
      4'h3: o_font = 8'hB0;
      4'h4: o_font = 8'h99;
      4'h5: o_font = 8'h92;
      4'h6: o_font = 8'h82;
      4'h7: o_font = 8'hF8;
      4'h8: o_font = 8'h80;
      4'h9: o_font = 8'h90;
      4'hA: o_font = FND_DP_ONLY;
      default: o_font = FND_BLANK;
    endcase
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 4-digit common-anode FND scanner.
//   i_clk, i_reset        : clock, asynchronous active-high reset
//   i_enable              : scan enable; low forces blank outputs
//   i_digit_value[15:0]   : four BCD nibbles, digit0 = [3:0] (rightmost)
//   i_blink_mask, i_dp_mask, i_lzb : per-digit blink / dp, leading-zero blank
//   o_fnd_com[3:0]        : active-low digit commons (registered)
//   o_fndfont[7:0]        : active-low segments, bit7 = dp (registered)
//   o_frame_start         : one-cycle pulse when a new snapshot is taken
// Each slot is SCAN_DIV cycles: DEAD_CYCLES blanked (ghosting guard), then the
// selected digit is driven until the next slot tick.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned DEAD_CYCLES = 1000,
  parameter int unsigned BLINK_TICKS = 500
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [15:0] i_digit_value,
  input  logic [3:0]  i_blink_mask,
  input  logic [3:0]  i_dp_mask,
  input  logic        i_lzb,
  output logic [3:0]  o_fnd_com,
  output logic [7:0]  o_fndfont,
  output logic        o_frame_start
);

  localparam int unsigned PRESC_W = $clog2(SCAN_DIV);
  localparam int unsigned DEAD_W  = $clog2(DEAD_CYCLES + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [DEAD_W-1:0]  DEAD_LAST  = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  scan_state_e        state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DEAD_W-1:0]  dead_q, dead_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [1:0]         idx_q, idx_d;
  logic               en_q, en_d;
  logic [15:0]        snap_val_q, snap_val_d;
  logic [3:0]         snap_blink_q, snap_blink_d;
  logic [3:0]         snap_dp_q, snap_dp_d;
  logic               snap_lzb_q, snap_lzb_d;
  logic [3:0]         com_q, com_d;
  logic [7:0]         font_q, font_d;
  logic               frame_start_q, frame_start_d;

  logic               slot_tick;
  logic               capture;
  logic [3:0]         cur_nibble;
  logic [7:0]         dec_font;
  logic [7:0]         digit_font;

  // One decoder shared by all digits, fed by the index-selected snapshot nibble.
  assign cur_nibble = snap_val_q[{idx_q, 2'b00} +: 4];

  BCDtoFND_Decoder u_decoder (
    .i_bcd  (cur_nibble),
    .o_font (dec_font)
  );

  // Sequencing: prescaler, slot index, dead counter, FSM, blink, snapshots.
  always_comb begin
    slot_tick     = i_enable && (presc_q == PRESC_LAST);
    // Snapshot on enable rising and whenever the index wraps back to 0.
    capture       = i_enable && (!en_q || (slot_tick && (idx_q == 2'd3)));

    presc_d       = presc_q;
    dead_d        = dead_q;
    idx_d         = idx_q;
    state_d       = state_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    en_d          = i_enable;
    snap_val_d    = snap_val_q;
    snap_blink_d  = snap_blink_q;
    snap_dp_d     = snap_dp_q;
    snap_lzb_d    = snap_lzb_q;
    frame_start_d = capture;

    if (!i_enable) begin
      // Blink counter and phase are held so blinking resumes seamlessly.
      presc_d = '0;
      dead_d  = '0;
      idx_d   = '0;
      state_d = BLANK;
    end else if (slot_tick) begin
      // Slot tick has priority over dead-count expiry.
      presc_d = '0;
      dead_d  = '0;
      idx_d   = idx_q + 2'd1;
      state_d = BLANK;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end else begin
      presc_d = presc_q + PRESC_W'(1);
      case (state_q)
        BLANK: begin
          if (dead_q == DEAD_LAST) state_d = DRIVE;
          else                     dead_d  = dead_q + DEAD_W'(1);
        end
        DRIVE:   state_d = DRIVE;
        default: state_d = BLANK;
      endcase
    end

    if (capture) begin
      snap_val_d   = i_digit_value;
      snap_blink_d = i_blink_mask;
      snap_dp_d    = i_dp_mask;
      snap_lzb_d   = i_lzb;
    end
  end

  // Output font/commons from the current state; registered for one-cycle latency.
  always_comb begin
    digit_font = dec_font;
    if (snap_dp_q[idx_q]) digit_font[7] = 1'b0;
    // Leading-zero blank and blink suppress the whole digit, dp included.
    if (snap_lzb_q && (idx_q == 2'd3) && (cur_nibble == 4'd0)) digit_font = FND_BLANK;
    if (blink_phase_q && snap_blink_q[idx_q])                  digit_font = FND_BLANK;

    com_d  = COM_OFF;
    font_d = FND_BLANK;
    if (i_enable && (state_q == DRIVE)) begin
      com_d  = ~(4'b0001 << idx_q);
      font_d = digit_font;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= BLANK;
      presc_q       <= '0;
      dead_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      idx_q         <= '0;
      en_q          <= 1'b0;
      snap_val_q    <= '0;
      snap_blink_q  <= '0;
      snap_dp_q     <= '0;
      snap_lzb_q    <= 1'b0;
      com_q         <= COM_OFF;
      font_q        <= FND_BLANK;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      dead_q        <= dead_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      idx_q         <= idx_d;
      en_q          <= en_d;
      snap_val_q    <= snap_val_d;
      snap_blink_q  <= snap_blink_d;
      snap_dp_q     <= snap_dp_d;
      snap_lzb_q    <= snap_lzb_d;
      com_q         <= com_d;
      font_q        <= font_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_fnd_com     = com_q;
  assign o_fndfont     = font_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with SCAN_DIV=8, DEAD_CYCLES=2,
// BLINK_TICKS=4. Sample point s counts negedges after reset release: s=0 is
// the first negedge after the first active edge. Frame 0 drives digit d at
// s=8d+2..8d+7; snapshot edges fall at s=32f-1, after which frame f drives
// digit d at s=32f+8d+2..32f+8d+7. Blink phase flips at every snapshot edge.
module tb_fnd_scan_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   s     = 0;

  fnd_scan_controller_if bus ();

  always #5 clk = ~clk;

  fnd_scan_controller #(
    .SCAN_DIV    (8),
    .DEAD_CYCLES (2),
    .BLINK_TICKS (4)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_enable      (bus.enable),
    .i_digit_value (bus.digit_value),
    .i_blink_mask  (bus.blink_mask),
    .i_dp_mask     (bus.dp_mask),
    .i_lzb         (bus.lzb),
    .o_fnd_com     (bus.fnd_com),
    .o_fndfont     (bus.fndfont),
    .o_frame_start (bus.frame_start)
  );

  task automatic tick();
    @(negedge clk);
    s++;
  endtask

  task automatic goto(input int t);
    while (s < t) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s @s=%0d: observed=%h expected=%h", tag, s, obs, expv);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] com_e, input logic [7:0] font_e);
    chk({tag, "_com"}, {4'h0, bus.fnd_com}, {4'h0, com_e});
    chk({tag, "_font"}, bus.fndfont, font_e);
  endtask

  task automatic chk_fs(input string tag, input logic fs_e);
    chk(tag, {7'd0, bus.frame_start}, {7'd0, fs_e});
  endtask

  initial begin
    bus.enable      = 1'b1;
    bus.digit_value = 16'h1234;
    bus.blink_mask  = 4'b0000;
    bus.dp_mask     = 4'b0000;
    bus.lzb         = 1'b0;
    repeat (2) @(negedge clk);
    chk_disp("reset", 4'hF, 8'hFF);
    chk_fs("reset_fs", 1'b0);

    // Reset scan of 1234.
    rst = 1'b0;
    s   = -1;
    tick();
    chk_fs("fs_first", 1'b1);
    chk_disp("s0_blank", 4'hF, 8'hFF);
    tick();
    chk_fs("fs_once", 1'b0);
    chk_disp("s1_blank", 4'hF, 8'hFF);
    goto(2);   chk_disp("d0_first", 4'b1110, 8'h99);
    goto(7);   chk_disp("d0_last", 4'b1110, 8'h99);
    goto(8);   chk_disp("dead0", 4'hF, 8'hFF);
    goto(9);   chk_disp("dead1", 4'hF, 8'hFF);
    goto(10);  chk_disp("d1", 4'b1101, 8'hB0);
    goto(18);  chk_disp("d2", 4'b1011, 8'hA4);
    goto(26);  chk_disp("d3", 4'b0111, 8'hF9);
    goto(31);  chk_fs("fs_wrap", 1'b1); chk_disp("d3_tail", 4'b0111, 8'hF9);
    goto(34);  chk_disp("d0_wrap", 4'b1110, 8'h99);

    // Snapshot: mid-frame change must not tear.
    goto(42);  bus.digit_value = 16'h5678;
    goto(50);  chk_disp("snap_d2_old", 4'b1011, 8'hA4);
    goto(58);  chk_disp("snap_d3_old", 4'b0111, 8'hF9);
    goto(63);  chk_fs("snap_fs", 1'b1);
    goto(66);  chk_disp("snap_d0_new", 4'b1110, 8'h80);
    goto(74);  chk_disp("snap_d1_new", 4'b1101, 8'hF8);

    // Blink on digit0, dp on digit1; snapshot taken at s=95.
    goto(80);
    bus.digit_value = 16'h1234;
    bus.blink_mask  = 4'b0001;
    bus.dp_mask     = 4'b0010;
    goto(98);  chk_disp("blink_on", 4'b1110, 8'hFF);
    goto(106); chk_disp("dp_d1", 4'b1101, 8'h30);
    goto(130); chk_disp("blink_off", 4'b1110, 8'h99);
    goto(162); chk_disp("blink_on2", 4'b1110, 8'hFF);

    // Leading-zero blank and special codes; snapshot taken at s=191.
    goto(165);
    bus.digit_value = 16'h0A0F;
    bus.lzb         = 1'b1;
    bus.blink_mask  = 4'b0000;
    bus.dp_mask     = 4'b1000;
    goto(194); chk_disp("code_f", 4'b1110, 8'hFF);
    goto(202); chk_disp("code_0", 4'b1101, 8'hC0);
    goto(210); chk_disp("code_a", 4'b1011, 8'h7F);
    goto(218); chk_disp("lzb_d3", 4'b0111, 8'hFF);

    // Enable drop during DRIVE, then re-enable.
    goto(220); bus.enable = 1'b0;
    goto(221); chk_disp("dis_blank", 4'hF, 8'hFF);
    bus.digit_value = 16'h1234;
    bus.lzb         = 1'b0;
    bus.dp_mask     = 4'b0000;
    goto(224); chk_fs("dis_fs", 1'b0); chk_disp("dis_hold", 4'hF, 8'hFF);
    bus.enable = 1'b1;
    goto(225); chk_fs("reen_fs", 1'b1);
    goto(226); chk_disp("reen_blank", 4'hF, 8'hFF);
    goto(227); chk_disp("reen_d0", 4'b1110, 8'h99);

    // Asynchronous reset mid-slot, then restart.
    goto(229); chk_disp("pre_rst", 4'b1110, 8'h99);
    #2 rst = 1'b1;
    #1 chk_disp("async_rst", 4'hF, 8'hFF);
    chk_fs("async_rst_fs", 1'b0);
    tick();
    chk_disp("rst_hold", 4'hF, 8'hFF);
    rst = 1'b0;
    tick();
    chk_fs("post_rst_fs", 1'b1);
    tick();
    tick();
    chk_disp("post_rst_d0", 4'b1110, 8'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
